// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_pkg
//  Description : Shared types and constants for the FND scan controller.
//                Holds the scan FSM state encoding, the active-high
//                7-segment glyph patterns {g,f,e,d,c,b,a} and the
//                hex_to_seg() lookup used by the hex decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fnd_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } fnd_state_e;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_hex_decoder
//  Description : Combinational hex nibble to 7-segment decoder. Output is
//                the active-high pattern {g,f,e,d,c,b,a}; pin polarity is
//                applied by the caller.
//  Ports       : nibble_i [3:0] - hex digit
//                seg_o    [6:0] - active-high segment pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module fnd_hex_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_controller
//  Description : Time-multiplexed scan controller for a multi-digit 7-segment
//                display. One slot per sampled fnd_clk rise, with all
//                commons forced off for BLANK_CYCLES between slots. Digit
//                data is snapshotted at the start of each slot; blink phase
//                is applied live.
//  Ports       : clock_50m  - system clock (fnd_clk/blink_clk are sampled)
//                reset      - synchronous, active-high
//                fnd_clk    - scan-rate reference level
//                blink_clk  - blink phase level
//                digit_data - 4 bits per digit, digit i = [4i+3:4i]
//                digit_en   - per-digit lit enable
//                dp_in      - per-digit decimal point
//                blink_en   - per-digit blink enable (blank when phase low)
//                fnd_seg    - {g,f,e,d,c,b,a}, registered, pin polarity
//                fnd_dp     - decimal point, registered, pin polarity
//                fnd_com    - digit commons, registered, pin polarity
//                scan_idx   - current slot index
//                frame_done - one-cycle pulse as the last slot ends
//  Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int BLANK_CYCLES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clock_50m,
  input  logic                  reset,
  input  logic                  fnd_clk,
  input  logic                  blink_clk,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            fnd_seg,
  output logic                  fnd_dp,
  output logic [DIGITS-1:0]     fnd_com,
  output logic [2:0]            scan_idx,
  output logic                  frame_done
);

  localparam int         CNT_W      = $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0] c_idx_last = 3'(DIGITS - 1);
  localparam logic       c_inv      = (ACTIVE_LOW != 0);

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic fnd_s1_q, fnd_s2_q, fnd_s3_q;
  logic blk_s1_q, blk_s2_q;
  logic w_tick;

  always_ff @(posedge clock_50m) begin
    if (reset) begin
      fnd_s1_q <= 1'b0;
      fnd_s2_q <= 1'b0;
      fnd_s3_q <= 1'b0;
      blk_s1_q <= 1'b0;
      blk_s2_q <= 1'b0;
    end else begin
      fnd_s1_q <= fnd_clk;
      fnd_s2_q <= fnd_s1_q;
      fnd_s3_q <= fnd_s2_q;
      blk_s1_q <= blink_clk;
      blk_s2_q <= blk_s1_q;
    end
  end

  assign w_tick = fnd_s2_q & ~fnd_s3_q;

  // --------------------------------------------------------------------------
  // Scan FSM
  // --------------------------------------------------------------------------
  fnd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             frame_q, frame_d;
  logic [3:0]       snap_nib_q, snap_nib_d;
  logic             snap_dp_q, snap_dp_d;
  logic             snap_en_q, snap_en_d;
  logic             snap_blink_q, snap_blink_d;

  always_ff @(posedge clock_50m) begin
    if (reset) begin
      state_q <= ST_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_d      = 1'b0;
    snap_nib_d   = snap_nib_q;
    snap_dp_d    = snap_dp_q;
    snap_en_d    = snap_en_q;
    snap_blink_d = snap_blink_q;

    case (state_q)
      ST_BLANK: begin
        // Ticks arriving here are dropped on purpose: queuing them would
        // shorten the next slot and make brightness uneven.
        if (cnt_q == c_cnt_last) begin
          snap_nib_d   = digit_data[{idx_q, 2'b00} +: 4];
          snap_dp_d    = dp_in[idx_q];
          snap_en_d    = digit_en[idx_q];
          snap_blink_d = blink_en[idx_q];
          cnt_d        = '0;
          state_d      = ST_SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (w_tick) begin
          idx_d   = (idx_q == c_idx_last) ? 3'd0 : idx_q + 3'd1;
          frame_d = (idx_q == c_idx_last);
          cnt_d   = '0;
          state_d = ST_BLANK;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_50m) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      frame_q      <= 1'b0;
      snap_nib_q   <= 4'd0;
      snap_dp_q    <= 1'b0;
      snap_en_q    <= 1'b0;
      snap_blink_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      snap_nib_q   <= snap_nib_d;
      snap_dp_q    <= snap_dp_d;
      snap_en_q    <= snap_en_d;
      snap_blink_q <= snap_blink_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic [6:0]        w_dec_seg;
  logic              w_lit;
  logic [DIGITS-1:0] w_com_act;
  logic [6:0]        w_seg_act;
  logic              w_dp_act;

  fnd_hex_decoder u_dec (
    .nibble_i (snap_nib_q),
    .seg_o    (w_dec_seg)
  );

  // Blink phase is taken live from the synchroniser, not from the snapshot,
  // so a phase change shows up mid-slot.
  assign w_lit = (state_q == ST_SHOW) && snap_en_q && !(snap_blink_q && !blk_s2_q);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_com
    assign w_com_act[gi] = w_lit && (idx_q == 3'(gi));
  end

  assign w_seg_act = w_lit ? w_dec_seg : SEG_OFF;
  assign w_dp_act  = w_lit & snap_dp_q;

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] com_q;

  always_ff @(posedge clock_50m) begin
    if (reset) begin
      seg_q <= {7{c_inv}};
      dp_q  <= c_inv;
      com_q <= {DIGITS{c_inv}};
    end else begin
      seg_q <= w_seg_act ^ {7{c_inv}};
      dp_q  <= w_dp_act ^ c_inv;
      com_q <= w_com_act ^ {DIGITS{c_inv}};
    end
  end

  assign fnd_seg    = seg_q;
  assign fnd_dp     = dp_q;
  assign fnd_com    = com_q;
  assign scan_idx   = idx_q;
  assign frame_done = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fnd_scan_controller
//  Description : Self-checking bench for fnd_scan_controller with
//                DIGITS=8, BLANK_CYCLES=4, ACTIVE_LOW=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_controller;

  typedef struct {
    logic [7:0] com;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        fnd_clk;
  logic        blink_clk;
  logic [31:0] digit_data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic [7:0]  blink_en;
  logic [6:0]  fnd_seg;
  logic        fnd_dp;
  logic [7:0]  fnd_com;
  logic [2:0]  scan_idx;
  logic        frame_done;

  int   total = 0;
  int   bad   = 0;
  int   half  = 8;
  exp_t sb[$];
  logic [6:0] hex_tab [16];

  fnd_scan_controller #(
    .DIGITS       (8),
    .BLANK_CYCLES (4),
    .ACTIVE_LOW   (1)
  ) dut (
    .clock_50m  (clk),
    .reset      (rst),
    .fnd_clk    (fnd_clk),
    .blink_clk  (blink_clk),
    .digit_data (digit_data),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .blink_en   (blink_en),
    .fnd_seg    (fnd_seg),
    .fnd_dp     (fnd_dp),
    .fnd_com    (fnd_com),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    fnd_clk = 1'b0;
    forever begin
      repeat (half) @(posedge clk);
      fnd_clk = ~fnd_clk;
    end
  end

  // Expected pin values for a slot, from the bench's own stimulus (no blink).
  function automatic exp_t model(input int k);
    exp_t       e;
    logic [7:0] one;
    logic [3:0] nib;
    one = 8'h01;
    nib = digit_data[4*k +: 4];
    if (digit_en[k]) begin
      e.com = ~(one << k);
      e.seg = ~hex_tab[nib];
      e.dp  = ~dp_in[k];
    end else begin
      e.com = 8'hFF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
    return e;
  endfunction

  // Returns at the first negedge after scan_idx changes to k.
  task automatic wait_slot(input logic [2:0] k, output bit to);
    logic [2:0] prev;
    prev = scan_idx;
    to   = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (scan_idx != prev) begin
        if (scan_idx == k) begin
          to = 1'b0;
          break;
        end
        prev = scan_idx;
      end
    end
  endtask

  // Samples the pins well inside the SHOW part of slot k.
  task automatic get_slot(input logic [2:0] k, output logic [7:0] com,
                          output logic [6:0] seg, output logic dp, output bit to);
    wait_slot(k, to);
    repeat (7) @(negedge clk);
    com = fnd_com;
    seg = fnd_seg;
    dp  = fnd_dp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (fnd_com !== 8'hFF) begin bad++; $display("FAIL reset_com got=%h exp=ff", fnd_com); end
    total++; if (fnd_seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", fnd_seg); end
    total++; if (fnd_dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", fnd_dp); end
    total++; if (scan_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", scan_idx); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b exp=0", frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [7:0] com; logic [6:0] seg; logic dp; bit to; exp_t e;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(model(i % 8));
      get_slot(3'(i % 8), com, seg, dp, to);
      e = sb.pop_front();
      total++;
      if (to) begin bad++; $display("FAIL scan_timeout slot=%0d", i % 8); continue; end
      if (com !== e.com || seg !== e.seg || dp !== e.dp) begin
        bad++;
        $display("FAIL scan_slot%0d got com=%h seg=%h dp=%b exp com=%h seg=%h dp=%b",
                 i % 8, com, seg, dp, e.com, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_blank_gap();
    bit to; int off;
    off = 0;
    wait_slot(3'd5, to);
    total++; if (to) begin bad++; $display("FAIL gap_timeout"); end
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (fnd_com === 8'hFF) off++;
    end
    total++; if (off != 4) begin bad++; $display("FAIL blank_gap got=%0d exp=4", off); end
  endtask

  task automatic test_frame_done();
    int pulses; int misaligned;
    pulses = 0; misaligned = 0;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        pulses++;
        if (scan_idx !== 3'd0) misaligned++;
      end
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL frame_count got=%0d exp=2", pulses); end
    total++; if (misaligned != 0) begin bad++; $display("FAIL frame_align got=%0d exp=0", misaligned); end
  endtask

  task automatic test_snapshot();
    logic [7:0] com; logic [6:0] seg; logic dp; bit to; exp_t e;
    sb.push_back(model(0));
    sb.push_back(model(0));
    get_slot(3'd0, com, seg, dp, to);
    e = sb.pop_front();
    total++; if (to || seg !== e.seg) begin bad++; $display("FAIL snap_before got=%h exp=%h to=%b", seg, e.seg, to); end
    digit_data[3:0] = 4'h8;
    repeat (3) @(negedge clk);
    e = sb.pop_front();
    total++; if (fnd_seg !== e.seg || fnd_com !== e.com) begin
      bad++; $display("FAIL snap_hold got seg=%h com=%h exp seg=%h com=%h", fnd_seg, fnd_com, e.seg, e.com);
    end
    sb.push_back(model(0));
    get_slot(3'd0, com, seg, dp, to);
    e = sb.pop_front();
    total++; if (to || seg !== e.seg || com !== e.com) begin
      bad++; $display("FAIL snap_next got seg=%h com=%h exp seg=%h com=%h", seg, com, e.seg, e.com);
    end
    digit_data[3:0] = 4'h0;
  endtask

  task automatic test_disabled();
    logic [7:0] com; logic [6:0] seg; logic dp; bit to; exp_t e; int lit; int len;
    digit_en = 8'hFB;
    sb.push_back(model(1));
    get_slot(3'd1, com, seg, dp, to);
    e = sb.pop_front();
    total++; if (to || com !== e.com || seg !== e.seg) begin
      bad++; $display("FAIL dis_slot1 got com=%h seg=%h exp com=%h seg=%h", com, seg, e.com, e.seg);
    end
    wait_slot(3'd2, to);
    lit = 0; len = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      len = n;
      if (scan_idx != 3'd2) break;
      if (fnd_com !== 8'hFF) lit++;
    end
    total++; if (to || lit != 0) begin bad++; $display("FAIL dis_slot2_lit got=%0d exp=0", lit); end
    total++; if (len != 16) begin bad++; $display("FAIL dis_period got=%0d exp=16", len); end
    sb.push_back(model(3));
    repeat (7) @(negedge clk);
    e = sb.pop_front();
    total++; if (fnd_com !== e.com || fnd_seg !== e.seg) begin
      bad++; $display("FAIL dis_slot3 got com=%h seg=%h exp com=%h seg=%h", fnd_com, fnd_seg, e.com, e.seg);
    end
    digit_en = 8'hFF;
  endtask

  task automatic test_blink();
    logic [7:0] com; logic [6:0] seg; logic dp; bit to;
    blink_en  = 8'h02;
    blink_clk = 1'b0;
    get_slot(3'd1, com, seg, dp, to);
    total++; if (to || com !== 8'hFF || seg !== 7'h7F) begin
      bad++; $display("FAIL blink_low got com=%h seg=%h exp com=ff seg=7f", com, seg);
    end
    blink_clk = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (fnd_com !== 8'hFD || fnd_seg !== 7'h79) begin
      bad++; $display("FAIL blink_high got com=%h seg=%h exp com=fd seg=79", fnd_com, fnd_seg);
    end
    blink_en = 8'h00;
  endtask

  task automatic test_reset_mid_show();
    bit to;
    wait_slot(3'd3, to);
    repeat (7) @(negedge clk);
    total++; if (to || fnd_com !== 8'hF7) begin bad++; $display("FAIL mid_show_pre got=%h exp=f7", fnd_com); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (fnd_com !== 8'hFF || fnd_seg !== 7'h7F || fnd_dp !== 1'b1 || scan_idx !== 3'd0) begin
      bad++; $display("FAIL mid_show_reset got com=%h seg=%h dp=%b idx=%0d exp com=ff seg=7f dp=1 idx=0",
                      fnd_com, fnd_seg, fnd_dp, scan_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_fast_tick();
    logic [2:0] prev; int len; bit moved;
    half = 2;
    repeat (40) @(negedge clk);
    prev = scan_idx;
    for (int c = 0; c < 5; c++) begin
      moved = 1'b0; len = 0;
      for (int n = 1; n <= 100; n++) begin
        @(negedge clk);
        len = n;
        if (scan_idx != prev) begin moved = 1'b1; break; end
      end
      total++; if (!moved) begin bad++; $display("FAIL fast_lockup got=stuck exp=advance"); break; end
      total++; if (scan_idx !== 3'(prev + 3'd1)) begin
        bad++; $display("FAIL fast_step got=%0d exp=%0d", scan_idx, 3'(prev + 3'd1));
      end
      if (c > 0) begin
        total++; if (len != 8) begin bad++; $display("FAIL fast_period got=%0d exp=8", len); end
      end
      prev = scan_idx;
    end
    half = 8;
  endtask

  initial begin
    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst        = 1'b1;
    blink_clk  = 1'b1;
    digit_data = 32'h76543210;
    digit_en   = 8'hFF;
    dp_in      = 8'h20;
    blink_en   = 8'h00;

    test_reset();
    test_scan();
    test_blank_gap();
    test_frame_done();
    test_snapshot();
    test_disabled();
    test_blink();
    test_reset_mid_show();
    test_fast_tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
